exec_sequencer: RTL and testbench

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_seq_pkg.sv | 14 +
 rtl/exec_sequencer_if.sv | 27 ++
 rtl/exec_sequencer_sat_counter.sv | 23 ++
 rtl/exec_sequencer.sv | 130 +++++++++++++
 tb/tb_exec_sequencer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_seq_pkg.sv
// Shared types and default sizing for the execute-stage sequencer.
package exec_seq_pkg;

   localparam int unsigned DefFpuTimeout = 255;
   localparam int unsigned DefCntW       = 32;

   typedef enum logic [1:0] {
      StIdle,
      StWaitAlu,
      StWaitFpu,
      StHold
   } seq_state_e;

endpackage

// File: rtl/exec_sequencer_if.sv
// Issue, unit-control and writeback signals of the execute sequencer.
interface exec_sequencer_if;

   logic in_valid;
   logic in_ready;
   logic in_is_fp;
   logic alu_start;
   logic fpu_start;
   logic alu_done;
   logic fpu_done;
   logic unit_jump;
   logic out_valid;
   logic out_ready;
   logic out_err;
   logic redirect;

   modport master (
      output in_valid, in_is_fp, alu_done, fpu_done, unit_jump, out_ready,
      input  in_ready, alu_start, fpu_start, out_valid, out_err, redirect
   );

   modport slave (
      input  in_valid, in_is_fp, alu_done, fpu_done, unit_jump, out_ready,
      output in_ready, alu_start, fpu_start, out_valid, out_err, redirect
   );

endinterface

// File: rtl/exec_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
   parameter int unsigned Width = 32
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [Width-1:0] count
);

   logic [Width-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (clear) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != {Width{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/exec_sequencer.sv
// Single-issue execute sequencer: dispatches one op to the ALU or FPU, waits for
// completion (FPU with timeout) and holds the result until writeback takes it.
module exec_sequencer
   import exec_seq_pkg::*;
#(
   parameter int unsigned FPU_TIMEOUT = DefFpuTimeout,
   parameter int unsigned CNT_W       = DefCntW
) (
   input  logic             clk,
   input  logic             rst,
   exec_sequencer_if.slave  bus,
   output logic             err_sticky,
   output logic [CNT_W-1:0] busy_cycles,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int unsigned     TmrW   = (FPU_TIMEOUT < 1) ? 1 : $clog2(FPU_TIMEOUT + 1);
   localparam logic [TmrW-1:0] TmrMax = TmrW'(FPU_TIMEOUT);

   seq_state_e      state_q;
   logic            alu_start_q;
   logic            fpu_start_q;
   logic            out_valid_q;
   logic            out_err_q;
   logic            jump_q;
   logic            err_sticky_q;
   logic [TmrW-1:0] tmr_q;

   logic hold_hs;
   logic accept_ok;
   logic accept;
   logic alu_ok;
   logic fpu_ok;
   logic fpu_timeout;
   logic hold_stall;

   assign hold_hs     = (state_q == StHold) && bus.out_ready;
   // A pending jump blocks issue so the wrong-path op behind it is dropped.
   assign accept_ok   = !rst && ((state_q == StIdle) || (hold_hs && !jump_q));
   assign accept      = accept_ok && bus.in_valid;
   // The start flag doubles as the "first WAIT cycle" marker: done is ignored there.
   assign alu_ok      = (state_q == StWaitAlu) && !alu_start_q && bus.alu_done;
   assign fpu_ok      = (state_q == StWaitFpu) && !fpu_start_q && bus.fpu_done;
   assign fpu_timeout = (state_q == StWaitFpu) && (tmr_q == TmrMax) && !fpu_ok;
   assign hold_stall  = (state_q == StHold) && !bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         alu_start_q  <= 1'b0;
         fpu_start_q  <= 1'b0;
         out_valid_q  <= 1'b0;
         out_err_q    <= 1'b0;
         jump_q       <= 1'b0;
         err_sticky_q <= 1'b0;
         tmr_q        <= '0;
      end else begin
         alu_start_q <= 1'b0;
         fpu_start_q <= 1'b0;
         case (state_q)
            StWaitAlu: begin
               if (alu_ok) begin
                  state_q     <= StHold;
                  out_valid_q <= 1'b1;
                  out_err_q   <= 1'b0;
                  jump_q      <= bus.unit_jump;
               end
            end
            StWaitFpu: begin
               tmr_q <= tmr_q + 1'b1;
               if (fpu_ok) begin
                  state_q     <= StHold;
                  out_valid_q <= 1'b1;
                  out_err_q   <= 1'b0;
                  jump_q      <= bus.unit_jump;
               end else if (fpu_timeout) begin
                  state_q      <= StHold;
                  out_valid_q  <= 1'b1;
                  out_err_q    <= 1'b1;
                  jump_q       <= 1'b0;
                  err_sticky_q <= 1'b1;
               end
            end
            StHold: begin
               if (hold_hs) begin
                  state_q     <= StIdle;
                  out_valid_q <= 1'b0;
                  out_err_q   <= 1'b0;
                  jump_q      <= 1'b0;
               end
            end
            default: ;
         endcase
         // Issue overrides the HOLD exit so a handshake can chain straight into WAIT.
         if (accept) begin
            state_q     <= bus.in_is_fp ? StWaitFpu : StWaitAlu;
            alu_start_q <= !bus.in_is_fp;
            fpu_start_q <= bus.in_is_fp;
            tmr_q       <= '0;
         end
      end
   end

   assign bus.in_ready  = accept_ok;
   assign bus.alu_start = alu_start_q;
   assign bus.fpu_start = fpu_start_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_err   = out_err_q;
   assign bus.redirect  = !rst && hold_hs && jump_q;
   assign err_sticky    = err_sticky_q;

   sat_counter #(
      .Width (CNT_W)
   ) u_busy_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (state_q != StIdle),
      .count (busy_cycles)
   );

   sat_counter #(
      .Width (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (hold_stall),
      .count (stall_cycles)
   );

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed timing checks plus randomized ops scored against a per-op result model.
module tb_exec_sequencer;

   localparam int unsigned T  = 4;
   localparam int unsigned CW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   exec_sequencer_if bus ();
   logic          err_sticky;
   logic [CW-1:0] busy_cycles;
   logic [CW-1:0] stall_cycles;

   exec_sequencer #(
      .FPU_TIMEOUT (T),
      .CNT_W       (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .err_sticky   (err_sticky),
      .busy_cycles  (busy_cycles),
      .stall_cycles (stall_cycles)
   );

   typedef struct packed {
      logic err;
      logic jump;
   } exp_t;

   exp_t sb_q[$];
   int   total      = 0;
   int   bad        = 0;
   logic rnd_phase  = 1'b0;
   logic exp_sticky = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic push(input logic err, input logic jump);
      exp_t e;
      e.err  = err;
      e.jump = jump;
      sb_q.push_back(e);
      if (err) exp_sticky = 1'b1;
   endtask

   // Random writeback back-pressure during the random phase.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_phase) bus.out_ready = ($urandom_range(0, 9) < 7);
      end
   end

   // Monitor: scores every writeback handshake and checks held results stay put.
   initial begin
      logic held;
      logic held_err;
      exp_t e;
      held = 1'b0;
      held_err = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            held = 1'b0;
         end else if (bus.out_valid) begin
            if (held) check("hold_stable_err", bus.out_err, held_err);
            if (bus.out_ready) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_result", 1, 0);
               end else begin
                  e = sb_q.pop_front();
                  check("result_err", bus.out_err, e.err);
                  check("result_redirect", bus.redirect, e.jump);
                  if (e.jump) check("in_ready_on_redirect", bus.in_ready, 0);
               end
               held = 1'b0;
            end else begin
               held = 1'b1;
               held_err = bus.out_err;
            end
         end else begin
            held = 1'b0;
            check("no_redirect_without_result", bus.redirect, 0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_is_fp  = 1'b0;
      bus.out_ready = 1'b0;
      bus.alu_done  = 1'b0;
      bus.fpu_done  = 1'b0;
      bus.unit_jump = 1'b0;
      repeat (2) cyc();
      mid();
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_alu_start", bus.alu_start, 0);
      check("rst_fpu_start", bus.fpu_start, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_err", bus.out_err, 0);
      check("rst_redirect", bus.redirect, 0);
      check("rst_sticky", err_sticky, 0);
      check("rst_busy", busy_cycles, 0);
      check("rst_stall", stall_cycles, 0);

      // ALU op, minimum latency; dones in IDLE and in the start cycle must be ignored.
      cyc(); rst = 1'b0; bus.in_valid = 1'b1; bus.in_is_fp = 1'b0; bus.out_ready = 1'b1;
      bus.alu_done = 1'b1; bus.fpu_done = 1'b1;
      mid(); check("first_cycle_ready", bus.in_ready, 1); push(1'b0, 1'b0);
      cyc(); bus.in_valid = 1'b0;
      mid(); check("alu_start_c1", bus.alu_start, 1); check("fpu_start_c1", bus.fpu_start, 0);
      check("wait_not_ready", bus.in_ready, 0); check("valid_c1", bus.out_valid, 0);
      cyc(); bus.fpu_done = 1'b0; bus.unit_jump = 1'b0;
      mid(); check("alu_start_c2", bus.alu_start, 0); check("valid_c2", bus.out_valid, 0);
      cyc(); bus.alu_done = 1'b0;
      mid(); check("valid_c3", bus.out_valid, 1); check("hold_ready_c3", bus.in_ready, 1);
      cyc();
      mid(); check("busy_after_alu", busy_cycles, 3); check("valid_c4", bus.out_valid, 0);

      // Jump: redirect on handshake, next op waits one IDLE cycle.
      cyc(); bus.in_valid = 1'b1;
      mid(); check("jump_op_ready", bus.in_ready, 1); push(1'b0, 1'b1);
      cyc(); bus.in_valid = 1'b0; bus.fpu_done = 1'b1;
      mid(); check("jump_op_start", bus.alu_start, 1);
      cyc();
      mid(); check("fpu_done_in_wait_alu", bus.out_valid, 0);
      cyc(); bus.fpu_done = 1'b0; bus.alu_done = 1'b1; bus.unit_jump = 1'b1;
      mid(); check("valid_before_done", bus.out_valid, 0);
      cyc(); bus.alu_done = 1'b0; bus.unit_jump = 1'b0; bus.in_valid = 1'b1;
      mid(); check("jump_redirect", bus.redirect, 1); check("jump_in_ready", bus.in_ready, 0);
      cyc();
      mid(); check("after_jump_ready", bus.in_ready, 1); check("after_jump_redir", bus.redirect, 0);
      push(1'b0, 1'b0);

      // Back-pressure for five HOLD cycles, then chained FPU issue.
      cyc(); bus.in_valid = 1'b0;
      mid(); check("bp_op_start", bus.alu_start, 1);
      cyc(); bus.alu_done = 1'b1; bus.out_ready = 1'b0;
      cyc(); bus.alu_done = 1'b0; bus.in_valid = 1'b1; bus.in_is_fp = 1'b1;
      for (int i = 0; i < 5; i++) begin
         mid();
         check("bp_valid", bus.out_valid, 1);
         check("bp_in_ready", bus.in_ready, 0);
         cyc();
      end
      bus.out_ready = 1'b1;
      mid(); check("b2b_ready", bus.in_ready, 1); push(1'b1, 1'b0);
      cyc(); bus.in_valid = 1'b0;
      mid(); check("stall_count", stall_cycles, 5); check("fpu_start_b2b", bus.fpu_start, 1);

      // FPU timeout with no done at all.
      for (int i = 1; i <= 4; i++) begin
         cyc();
         mid(); check("to_valid_early", bus.out_valid, 0);
      end
      check("sticky_before_to", err_sticky, 0);
      cyc(); bus.in_valid = 1'b1; bus.in_is_fp = 1'b1;
      mid(); check("to_valid", bus.out_valid, 1); check("to_err", bus.out_err, 1);
      check("to_sticky", err_sticky, 1); check("to_b2b_ready", bus.in_ready, 1);
      push(1'b0, 1'b0);

      // FPU done exactly at the timeout count wins.
      cyc(); bus.in_valid = 1'b0;
      mid(); check("fpu_start_edge", bus.fpu_start, 1);
      for (int i = 1; i <= 3; i++) begin
         cyc();
         mid(); check("edge_valid_early", bus.out_valid, 0);
      end
      cyc(); bus.fpu_done = 1'b1; bus.unit_jump = 1'b0;
      mid(); check("edge_valid_c4", bus.out_valid, 0);
      cyc(); bus.fpu_done = 1'b0;
      mid(); check("edge_valid", bus.out_valid, 1); check("edge_err", bus.out_err, 0);
      check("edge_sticky_kept", err_sticky, 1);

      // Reset in WAIT_FPU abandons the op; later fpu_done pulses do nothing.
      cyc(); bus.in_valid = 1'b1; bus.in_is_fp = 1'b1;
      mid(); check("rst_op_ready", bus.in_ready, 1);
      cyc(); bus.in_valid = 1'b0;
      mid(); check("rst_op_start", bus.fpu_start, 1);
      cyc(); rst = 1'b1;
      mid(); check("mid_rst_ready", bus.in_ready, 0); check("mid_rst_redirect", bus.redirect, 0);
      cyc(); rst = 1'b0; bus.fpu_done = 1'b1; exp_sticky = 1'b0;
      mid(); check("post_rst_valid", bus.out_valid, 0); check("post_rst_start", bus.fpu_start, 0);
      check("post_rst_sticky", err_sticky, 0); check("post_rst_busy", busy_cycles, 0);
      check("post_rst_stall", stall_cycles, 0); check("post_rst_ready", bus.in_ready, 1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         mid(); check("post_rst_done_ignored", bus.out_valid, 0);
      end
      cyc(); bus.fpu_done = 1'b0;

      // Random phase.
      rnd_phase = 1'b1;
      for (int op = 0; op < 120; op++) begin
         int unsigned d;
         int          n;
         logic        fp;
         logic        jmp;
         logic        to;
         logic        ok;
         fp  = 1'($urandom_range(0, 1));
         jmp = 1'($urandom_range(0, 1));
         d   = fp ? $urandom_range(1, T + 2) : $urandom_range(1, 4);
         to  = fp && (d > T);
         repeat ($urandom_range(0, 3) == 0 ? 1 : 0) begin
            cyc();
            bus.alu_done = 1'($urandom_range(0, 1));
            bus.fpu_done = 1'($urandom_range(0, 1));
         end
         cyc(); bus.alu_done = 1'b0; bus.fpu_done = 1'b0; bus.in_valid = 1'b1; bus.in_is_fp = fp;
         ok = 1'b0;
         n  = 0;
         while (n < 100) begin
            mid();
            if (bus.in_ready) begin
               ok = 1'b1;
               break;
            end
            cyc();
            n++;
         end
         if (!ok) begin
            check("accept_wait_expired", 0, 1);
            break;
         end
         push(to, to ? 1'b0 : jmp);
         cyc();
         bus.in_valid  = 1'b0;
         bus.in_is_fp  = 1'($urandom_range(0, 1));
         bus.unit_jump = 1'($urandom_range(0, 1));
         bus.alu_done  = fp ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 1));
         bus.fpu_done  = 1'($urandom_range(0, 1));
         mid(); check("rnd_alu_start", bus.alu_start, !fp); check("rnd_fpu_start", bus.fpu_start, fp);
         for (int unsigned c = 1; c <= d; c++) begin
            cyc();
            bus.unit_jump = (c == d) ? jmp : 1'($urandom_range(0, 1));
            if (fp) begin
               bus.fpu_done = (c == d) && !to;
               bus.alu_done = 1'($urandom_range(0, 1));
            end else begin
               bus.alu_done = (c == d);
               bus.fpu_done = 1'($urandom_range(0, 1));
            end
         end
      end
      cyc(); bus.alu_done = 1'b0; bus.fpu_done = 1'b0; bus.in_valid = 1'b0;
      for (int n = 0; n < 200 && sb_q.size() != 0; n++) cyc();
      repeat (2) cyc();
      mid();
      check("drain_empty", sb_q.size(), 0);
      check("busy_saturated", busy_cycles, {CW{1'b1}});
      check("final_sticky", err_sticky, exp_sticky);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
